instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/mips_pkg.sv | 72 +++++++
 rtl/instr_field_pack.sv | 38 +++
 rtl/instr_encoder.sv | 105 ++++++++++
 tb/tb_instr_encoder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants, mnemonic/state enums and field-packing helpers.
package mips_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned TGT_W   = 26;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned MNEM_W  = 4;
  localparam int unsigned WORD_W  = 32;

  typedef enum logic [MNEM_W-1:0] {
    MN_ADD  = 4'd0,
    MN_SUB  = 4'd1,
    MN_AND  = 4'd2,
    MN_OR   = 4'd3,
    MN_SLT  = 4'd4,
    MN_ADDI = 4'd5,
    MN_ANDI = 4'd6,
    MN_ORI  = 4'd7,
    MN_SLTI = 4'd8,
    MN_LW   = 4'd9,
    MN_SW   = 4'd10,
    MN_BEQ  = 4'd11,
    MN_BNE  = 4'd12,
    MN_J    = 4'd13
  } mnem_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FULL
  } enc_state_e;

  // Primary opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  function automatic logic [WORD_W-1:0] pack_r(input logic [REG_W-1:0]   rs,
                                               input logic [REG_W-1:0]   rt,
                                               input logic [REG_W-1:0]   rd,
                                               input logic [FUNCT_W-1:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'h00, funct};
  endfunction

  function automatic logic [WORD_W-1:0] pack_i(input logic [OP_W-1:0]  op,
                                               input logic [REG_W-1:0] rs,
                                               input logic [REG_W-1:0] rt,
                                               input logic [IMM_W-1:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [WORD_W-1:0] pack_j(input logic [TGT_W-1:0] target);
    return {OP_J, target};
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational mnemonic + field packer: produces the 32-bit word and a legal flag.
module instr_field_pack
  import mips_pkg::*;
(
  input  logic [MNEM_W-1:0] mnem,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  input  logic [IMM_W-1:0]  imm,
  input  logic [TGT_W-1:0]  target,
  output logic              legal,
  output logic [WORD_W-1:0] word
);

  // Select the encoding format by mnemonic; codes 14-15 are flagged illegal.
  always_comb begin
    legal = 1'b1;
    word  = '0;
    case (mnem_e'(mnem))
      MN_ADD:  word = pack_r(rs, rt, rd, FN_ADD);
      MN_SUB:  word = pack_r(rs, rt, rd, FN_SUB);
      MN_AND:  word = pack_r(rs, rt, rd, FN_AND);
      MN_OR:   word = pack_r(rs, rt, rd, FN_OR);
      MN_SLT:  word = pack_r(rs, rt, rd, FN_SLT);
      MN_ADDI: word = pack_i(OP_ADDI, rs, rt, imm);
      MN_ANDI: word = pack_i(OP_ANDI, rs, rt, imm);
      MN_ORI:  word = pack_i(OP_ORI,  rs, rt, imm);
      MN_SLTI: word = pack_i(OP_SLTI, rs, rt, imm);
      MN_LW:   word = pack_i(OP_LW,   rs, rt, imm);
      MN_SW:   word = pack_i(OP_SW,   rs, rt, imm);
      MN_BEQ:  word = pack_i(OP_BEQ,  rs, rt, imm);
      MN_BNE:  word = pack_i(OP_BNE,  rs, rt, imm);
      MN_J:    word = pack_j(target);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts descriptors, packs them into MIPS words and
// writes them sequentially into an instruction memory until it is full.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  enc_state_e        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_inc;
  logic              err_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              legal;
  logic [31:0]       word;
  logic              xfer;
  logic              wr;

  instr_field_pack u_pack (
    .mnem   (in_mnem),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .imm    (in_imm),
    .target (in_target),
    .legal  (legal),
    .word   (word)
  );

  // Handshake and next-count computation.
  always_comb begin
    in_ready = (state == ST_RUN) && (cnt != DEPTH) && !start;
    xfer     = in_valid && in_ready;
    wr       = xfer && legal;
    cnt_inc  = cnt + {{ADDR_W{1'b0}}, wr};
  end

  // FSM, pointer, count, sticky error and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (start) begin
      state <= ST_RUN;
      ptr   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
      we_q  <= 1'b0;
    end else begin
      we_q <= wr;
      if (wr) begin
        addr_q  <= ptr;
        wdata_q <= word;
        ptr     <= ptr + ADDR_W'(1);
        cnt     <= cnt_inc;
      end
      if (xfer && !legal) err_q <= 1'b1;
      if (state == ST_RUN) begin
        if (stop)                  state <= ST_IDLE;
        else if (cnt_inc == DEPTH) state <= ST_FULL;
      end
    end
  end

  // The write registered on the transfer edge is suppressed combinationally
  // when start arrives in its issue cycle, so a restart cancels it.
  always_comb begin
    imem_we    = we_q && !start;
    imem_addr  = addr_q;
    imem_wdata = wdata_q;
    count      = cnt;
    full       = (state == ST_FULL);
    err        = err_q;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed literal cases plus randomized
// traffic compared every cycle against a behavioural model.
module tb_instr_encoder;

  localparam int unsigned ADDR_W = 2;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_FULL = 2;

  localparam int FUNCT_TAB[5] = '{'h20, 'h22, 'h24, 'h25, 'h2A};
  localparam int OP_TAB[8]    = '{'h08, 'h0C, 'h0D, 'h0A, 'h23, 'h2B, 'h04, 'h05};

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_mnem = '0;
  logic [4:0]        in_rs = '0;
  logic [4:0]        in_rt = '0;
  logic [4:0]        in_rd = '0;
  logic [15:0]       in_imm = '0;
  logic [25:0]       in_target = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int          m_state = M_IDLE;
  int          m_ptr   = 0;
  int          m_cnt   = 0;
  bit          m_err   = 1'b0;
  bit          m_pend  = 1'b0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_data  = '0;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mnem    (in_mnem),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .in_target  (in_target),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .full       (full),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding from the instruction-format rules, using shifts and tables.
  function automatic logic [31:0] ref_word(input int mn, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] w;
    if (mn < 5)
      w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(FUNCT_TAB[mn]);
    else if (mn < 13)
      w = (32'(OP_TAB[mn-5]) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    else
      w = (32'h02 << 26) | 32'(tgt);
    return w;
  endfunction

  // Behavioural model, advanced on each clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= M_IDLE; m_ptr <= 0; m_cnt <= 0; m_err <= 1'b0;
      m_pend <= 1'b0; m_addr <= '0; m_data <= '0;
    end else if (start) begin
      m_state <= M_RUN; m_ptr <= 0; m_cnt <= 0; m_err <= 1'b0; m_pend <= 1'b0;
    end else begin
      automatic bit take = in_valid && (m_state == M_RUN) && (m_cnt != DEPTH);
      automatic bit ok   = take && (int'(in_mnem) < 14);
      automatic int ncnt = m_cnt + (ok ? 1 : 0);
      m_pend <= ok;
      if (ok) begin
        m_addr <= 32'(m_ptr);
        m_data <= ref_word(int'(in_mnem), in_rs, in_rt, in_rd, in_imm, in_target);
        m_ptr  <= (m_ptr + 1) % DEPTH;
        m_cnt  <= ncnt;
      end
      if (take && !ok) m_err <= 1'b1;
      if (m_state == M_RUN) begin
        if (stop)               m_state <= M_IDLE;
        else if (ncnt == DEPTH) m_state <= M_FULL;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    automatic logic exp_rdy = rst_n && (m_state == M_RUN) && (m_cnt != DEPTH) && !start;
    automatic logic exp_we  = m_pend && !start;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("imem_we", 32'(imem_we), 32'(exp_we));
    if (exp_we) begin
      check("imem_addr", 32'(imem_addr), m_addr);
      check("imem_wdata", imem_wdata, m_data);
    end
    check("count", 32'(count), 32'(m_cnt));
    check("full", 32'(full), 32'(m_state == M_FULL));
    check("err", 32'(err), 32'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int mn, input int rs, input int rt, input int rd,
                       input int imm, input int tgt);
    in_valid  = 1'b1;
    in_mnem   = 4'(mn);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_imm    = 16'(imm);
    in_target = 26'(tgt);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 32'(imem_we), 0);
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    tick();

    // model pinned to hand-encoded words
    check("model_add", ref_word(0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0), 32'h00221820);
    check("model_j", ref_word(13, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000), 32'h08100000);

    // ADD rs=1 rt=2 rd=3
    pulse_start();
    drive(0, 1, 2, 3, 0, 0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("add_we", 32'(imem_we), 1);
    check("add_addr", 32'(imem_addr), 0);
    check("add_wdata", imem_wdata, 32'h00221820);
    check("add_count", 32'(count), 1);
    tick();

    // LW then BEQ back to back
    pulse_start();
    drive(9, 29, 8, 0, 4, 0);
    tick();
    drive(11, 4, 5, 0, 'hFFFF, 0);
    @(negedge clk);
    check("lw_we", 32'(imem_we), 1);
    check("lw_addr", 32'(imem_addr), 0);
    check("lw_wdata", imem_wdata, 32'h8FA80004);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("beq_we", 32'(imem_we), 1);
    check("beq_addr", 32'(imem_addr), 1);
    check("beq_wdata", imem_wdata, 32'h1085FFFF);
    check("beq_count", 32'(count), 2);
    tick();

    // J
    drive(13, 0, 0, 0, 0, 'h0100000);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("j_wdata", imem_wdata, 32'h08100000);
    check("j_addr", 32'(imem_addr), 2);
    tick();

    // illegal mnemonic
    pulse_start();
    drive(15, 1, 1, 1, 1, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("ill_we", 32'(imem_we), 0);
    check("ill_err", 32'(err), 1);
    check("ill_count", 32'(count), 0);
    repeat (3) tick();
    check("ill_err_hold", 32'(err), 1);
    pulse_start();
    check("ill_err_clr", 32'(err), 0);

    // fill to DEPTH, fifth descriptor refused
    for (int i = 0; i < DEPTH; i++) begin
      drive(5, i, i + 1, 0, i * 3, 0);
      tick();
    end
    drive(6, 7, 7, 7, 7, 7);
    @(negedge clk);
    check("full_flag", 32'(full), 1);
    check("full_ready", 32'(in_ready), 0);
    check("full_count", 32'(count), 32'(DEPTH));
    check("full_last_addr", 32'(imem_addr), 32'(DEPTH - 1));
    tick();
    @(negedge clk);
    check("full_no_we", 32'(imem_we), 0);
    check("full_count_hold", 32'(count), 32'(DEPTH));
    in_valid = 1'b0;
    tick();

    // transfer then start: pending write cancelled
    pulse_start();
    drive(1, 3, 4, 5, 0, 0);
    tick();
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check("cancel_we", 32'(imem_we), 0);
    tick();
    start = 1'b0;
    @(negedge clk);
    check("cancel_count", 32'(count), 0);
    check("cancel_run", 32'(in_ready), 1);
    tick();

    // stop with write pending: write still issues
    drive(2, 6, 7, 8, 0, 0);
    tick();
    in_valid = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    check("stop_we", 32'(imem_we), 1);
    tick();
    stop = 1'b0;
    @(negedge clk);
    check("stop_idle", 32'(in_ready), 0);
    tick();

    // asynchronous reset while a write is pending
    pulse_start();
    drive(3, 1, 2, 3, 0, 0);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_we", 32'(imem_we), 0);
    check("arst_addr", 32'(imem_addr), 0);
    check("arst_wdata", imem_wdata, 0);
    check("arst_count", 32'(count), 0);
    check("arst_full", 32'(full), 0);
    check("arst_err", 32'(err), 0);
    check("arst_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom % 16) == 0;
      stop      = ($urandom % 20) == 0;
      in_valid  = ($urandom % 10) < 7;
      in_mnem   = 4'($urandom % 16);
      in_rs     = 5'($urandom);
      in_rt     = 5'($urandom);
      in_rd     = 5'($urandom);
      in_imm    = 16'($urandom);
      in_target = 26'($urandom);
      tick();
    end
    start = 1'b0;
    stop = 1'b0;
    in_valid = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
